// File: rtl/noc_fifo_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : noc_fifo_arbiter                                                 |
// | Brief   : Round-robin pop scheduler feeding N_REQ input FIFOs into one     |
// |           valid/ready NoC link through a 2-entry output buffer.           |
// |           Define NOC_ARB_PKT_LOCK_EN for packet-locked arbitration.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module noc_fifo_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int D_WIDTH = 16,
  parameter  int DEPTH   = 12,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int SW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_req_empty,
  input  logic [N_REQ*CW-1:0]        i_req_count,
  input  logic [N_REQ*D_WIDTH-1:0]   i_req_rd_data,
  output logic [N_REQ-1:0]           o_req_rd_en,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [D_WIDTH-1:0]         o_out_data,
  output logic [SW-1:0]              o_out_src
);

  localparam logic [SW:0] C_NREQ = (SW+1)'(N_REQ);
  localparam logic [SW:0] C_ONE  = (SW+1)'(1);

  logic [N_REQ-1:0]   w_elig_raw;
  logic [N_REQ-1:0]   w_elig;
  logic               w_gate;
  logic               w_found;
  logic [SW-1:0]      w_gnt_idx;
  logic               w_room;
  logic               w_issue;
  logic               w_pop_out;
  logic               w_cap;
  logic [D_WIDTH-1:0] w_cap_data;

  logic [1:0]         r_occ;
  logic               r_pend;
  logic [SW-1:0]      r_pend_src;
  logic [SW-1:0]      r_rr_ptr;
  logic [D_WIDTH-1:0] r_buf_data [2];
  logic [SW-1:0]      r_buf_src  [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;

  function automatic logic [SW-1:0] f_wrap(input logic [SW:0] s);
    if (s >= C_NREQ) return SW'(s - C_NREQ);
    return s[SW-1:0];
  endfunction

  // Count and the registered empty flag must both agree: empty lags count.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_elig
      assign w_elig_raw[gi] = (i_req_count[gi*CW +: CW] != '0) && !i_req_empty[gi];
    end
  endgenerate

`ifdef NOC_ARB_PKT_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_lock_src;

  always_comb begin
    w_elig = w_elig_raw;
    if (r_state == ST_LOCKED) w_elig = w_elig_raw & (N_REQ'(1) << r_lock_src);
  end

  // Only one flit in flight so the tail is seen before any further pop.
  assign w_gate = !r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lock_src <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state    <= ST_LOCKED;
            r_lock_src <= w_gnt_idx;
          end
        end
        ST_LOCKED: begin
          if (w_cap && w_cap_data[D_WIDTH-1]) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= f_wrap({1'b0, r_lock_src} + C_ONE);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign w_elig = w_elig_raw;
  assign w_gate = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= f_wrap({1'b0, w_gnt_idx} + C_ONE);
    end
  end
`endif

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = r_rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[f_wrap({1'b0, r_rr_ptr} + k[SW:0])]) begin
        w_found   = 1'b1;
        w_gnt_idx = f_wrap({1'b0, r_rr_ptr} + k[SW:0]);
      end
    end
  end

  assign w_pop_out  = o_out_valid && i_out_ready;
  // occ + pend - pop_out <= 1, rearranged to stay unsigned.
  assign w_room     = ({1'b0, r_occ} + {2'b00, r_pend}) <= (3'd1 + {2'b00, w_pop_out});
  assign w_issue    = w_found && w_room && w_gate && !rst;
  assign o_req_rd_en = w_issue ? (N_REQ'(1) << w_gnt_idx) : '0;

  assign w_cap      = r_pend;
  assign w_cap_data = i_req_rd_data[int'(r_pend_src)*D_WIDTH +: D_WIDTH];

  assign o_out_valid = (r_occ != 2'd0);
  assign o_out_data  = r_buf_data[r_rd_ptr];
  assign o_out_src   = r_buf_src[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ         <= 2'd0;
      r_pend        <= 1'b0;
      r_pend_src    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_src[0]  <= '0;
      r_buf_src[1]  <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) r_pend_src <= w_gnt_idx;
      if (w_cap) begin
        r_buf_data[r_wr_ptr] <= w_cap_data;
        r_buf_src[r_wr_ptr]  <= r_pend_src;
        r_wr_ptr             <= !r_wr_ptr;
      end
      if (w_pop_out) r_rd_ptr <= !r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_cap} - {1'b0, w_pop_out};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_fifo_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_noc_fifo_arbiter                                              |
// | Brief   : Directed bench for noc_fifo_arbiter with a behavioural FIFO      |
// |           model; honours NOC_ARB_PKT_LOCK_EN.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_noc_fifo_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 5;
`ifdef NOC_ARB_PKT_LOCK_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m_rst = 1'b1;
  logic [N-1:0]    w_emp;
  logic [N*CW-1:0] w_cnt;
  logic [N*DW-1:0] w_rdd;
  logic [N-1:0]    rd_en;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;

  always #5 clk = ~clk;

  noc_fifo_arbiter #(.N_REQ(N), .D_WIDTH(DW), .DEPTH(12)) dut (
    .clk(clk), .rst(rst), .i_req_empty(w_emp), .i_req_count(w_cnt),
    .i_req_rd_data(w_rdd), .o_req_rd_en(rd_en), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_src(out_src)
  );

  // Behavioural input FIFOs: count lags pop by a cycle, empty lags count.
  logic [DW-1:0] mem [N][64];
  int            wp [N];
  int            rp [N];
  int            padd [N];
  logic [CW-1:0] cnt [N];
  logic          emp [N];
  logic [DW-1:0] rdd [N];

  always_comb begin
    w_cnt = '0;
    w_emp = '0;
    w_rdd = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt[i*CW +: CW] = cnt[i];
      w_emp[i]          = emp[i];
      w_rdd[i*DW +: DW] = rdd[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (m_rst) begin
        cnt[i] <= '0;
        emp[i] <= 1'b1;
        rdd[i] <= '0;
        rp[i]  <= 0;
      end else begin
        if (rd_en[i]) begin
          rdd[i] <= mem[i][rp[i] % 64];
          rp[i]  <= rp[i] + 1;
        end
        cnt[i] <= CW'(int'(cnt[i]) + padd[i] - (rd_en[i] ? 1 : 0));
        emp[i] <= (cnt[i] == '0);
      end
    end
  end

  int            cyc = 0;
  int            pop_c[$];
  logic [N-1:0]  pop_v[$];
  int            acc_c[$];
  logic [DW-1:0] acc_d[$];
  logic [1:0]    acc_s[$];
  int            ohbad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en != '0) begin
        pop_c.push_back(cyc);
        pop_v.push_back(rd_en);
      end
      if (out_valid && out_ready) begin
        acc_c.push_back(cyc);
        acc_d.push_back(out_data);
        acc_s.push_back(out_src);
      end
      if ((rd_en & (rd_en - 1'b1)) != '0) ohbad = ohbad + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] flit(int src, int seq, bit tail);
    return {tail, 7'(src), 8'(seq)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // pkt=1: tail only on the last flit; otherwise every flit is a tail.
  task automatic stage(int i, int n, bit pkt);
    for (int k = 0; k < n; k++) begin
      mem[i][wp[i] % 64] = flit(i, wp[i], !pkt || (k == n - 1));
      wp[i] = wp[i] + 1;
    end
    padd[i] = n;
  endtask

  task automatic commit();
    tick();
    for (int i = 0; i < N; i++) padd[i] = 0;
  endtask

  task automatic clear_logs();
    pop_c.delete(); pop_v.delete();
    acc_c.delete(); acc_d.delete(); acc_s.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_acc(int n, int budget, output bit ok);
    int c = 0;
    while (acc_d.size() < n && c < budget) begin
      tick();
      c++;
    end
    ok = (acc_d.size() >= n);
  endtask

  task automatic test_reset();
    int b [N];
    bit ok;
    rst = 1'b1;
    out_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      b[i] = wp[i];
      stage(i, 2, 1'b0);
    end
    commit();
    tick();
    tick();
    vectors++; if (rd_en !== 4'b0000) begin miscompares++; $display("FAIL reset_rd_en got %b exp 0000", rd_en); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h exp 0000", out_data); end
    vectors++; if (out_src !== 2'd0) begin miscompares++; $display("FAIL reset_src got %0d exp 0", out_src); end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++; if (rd_en !== 4'b0001) begin miscompares++; $display("FAIL reset_first_pop got %b exp 0001", rd_en); end
    wait_acc(8, 80, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL reset_drain got %0d flits exp 8", acc_d.size()); end
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (acc_d[k] !== flit(k % 4, b[k % 4] + k / 4, 1'b1)) begin
          miscompares++; $display("FAIL reset_drain_data[%0d] got %h exp %h", k, acc_d[k], flit(k % 4, b[k % 4] + k / 4, 1'b1));
        end
      end
    end
  endtask

  task automatic test_single();
    int b;
    do_reset();
    clear_logs();
    out_ready = 1'b1;
    b = wp[2];
    stage(2, 3, 1'b0);
    commit();
    repeat (14) tick();
    vectors++; if (pop_c.size() != 3) begin miscompares++; $display("FAIL single_pops got %0d exp 3", pop_c.size()); end
    vectors++; if (acc_d.size() != 3) begin miscompares++; $display("FAIL single_accepts got %0d exp 3", acc_d.size()); end
    if (pop_c.size() == 3 && acc_d.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        vectors++; if (pop_v[k] !== 4'b0100) begin miscompares++; $display("FAIL single_rd_en[%0d] got %b exp 0100", k, pop_v[k]); end
        vectors++; if (acc_c[k] != pop_c[0] + 2 + GAP * k) begin miscompares++; $display("FAIL single_valid_cycle[%0d] got %0d exp %0d", k, acc_c[k], pop_c[0] + 2 + GAP * k); end
        vectors++; if (acc_s[k] !== 2'd2) begin miscompares++; $display("FAIL single_src[%0d] got %0d exp 2", k, acc_s[k]); end
        vectors++; if (acc_d[k] !== flit(2, b + k, 1'b1)) begin miscompares++; $display("FAIL single_data[%0d] got %h exp %h", k, acc_d[k], flit(2, b + k, 1'b1)); end
      end
      for (int k = 1; k < 3; k++) begin
        vectors++; if (pop_c[k] != pop_c[0] + GAP * k) begin miscompares++; $display("FAIL single_pop_cycle[%0d] got %0d exp %0d", k, pop_c[k], pop_c[0] + GAP * k); end
      end
    end
  endtask

  task automatic test_fairness();
    int b [N];
    bit ok;
    do_reset();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      b[i] = wp[i];
      stage(i, 5, 1'b0);
    end
    commit();
    wait_acc(20, 150, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fair_count got %0d exp 20", acc_d.size()); end
    if (ok) begin
      for (int k = 0; k < 20; k++) begin
        vectors++; if (acc_s[k] !== 2'(k % 4)) begin miscompares++; $display("FAIL fair_src[%0d] got %0d exp %0d", k, acc_s[k], k % 4); end
        vectors++; if (acc_d[k] !== flit(k % 4, b[k % 4] + k / 4, 1'b1)) begin miscompares++; $display("FAIL fair_data[%0d] got %h exp %h", k, acc_d[k], flit(k % 4, b[k % 4] + k / 4, 1'b1)); end
        if (k > 0) begin
          vectors++; if (acc_c[k] - acc_c[k-1] != GAP) begin miscompares++; $display("FAIL fair_spacing[%0d] got %0d exp %0d", k, acc_c[k] - acc_c[k-1], GAP); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b;
    bit ok;
    do_reset();
    clear_logs();
    out_ready = 1'b0;
    b = wp[1];
    stage(1, 4, 1'b0);
    commit();
    repeat (8) tick();
    vectors++; if (pop_c.size() != 2) begin miscompares++; $display("FAIL bp_pops got %0d exp 2", pop_c.size()); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %b exp 1", out_valid); end
    vectors++; if (out_src !== 2'd1) begin miscompares++; $display("FAIL bp_src got %0d exp 1", out_src); end
    vectors++; if (out_data !== flit(1, b, 1'b1)) begin miscompares++; $display("FAIL bp_data got %h exp %h", out_data, flit(1, b, 1'b1)); end
    tick();
    tick();
    vectors++; if (out_data !== flit(1, b, 1'b1)) begin miscompares++; $display("FAIL bp_data_stable got %h exp %h", out_data, flit(1, b, 1'b1)); end
    vectors++; if (pop_c.size() != 2) begin miscompares++; $display("FAIL bp_pops_hold got %0d exp 2", pop_c.size()); end
    out_ready = 1'b1;
    wait_acc(4, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_release got %0d flits exp 4", acc_d.size()); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        vectors++; if (acc_d[k] !== flit(1, b + k, 1'b1)) begin miscompares++; $display("FAIL bp_order[%0d] got %h exp %h", k, acc_d[k], flit(1, b + k, 1'b1)); end
      end
    end
  endtask

  task automatic test_lagged_empty();
    int b;
    bit ok;
    do_reset();
    clear_logs();
    out_ready = 1'b1;
    b = wp[3];
    stage(3, 1, 1'b0);
    commit();
    vectors++; if (rd_en !== 4'b0000) begin miscompares++; $display("FAIL lag_no_pop got %b exp 0000", rd_en); end
    tick();
    vectors++; if (rd_en !== 4'b1000) begin miscompares++; $display("FAIL lag_pop got %b exp 1000", rd_en); end
    wait_acc(1, 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL lag_accept got %0d flits exp 1", acc_d.size()); end
    if (ok) begin
      vectors++; if (acc_d[0] !== flit(3, b, 1'b1)) begin miscompares++; $display("FAIL lag_data got %h exp %h", acc_d[0], flit(3, b, 1'b1)); end
    end
  endtask

  task automatic test_mid_reset();
    int b;
    bit ok;
    do_reset();
    clear_logs();
    out_ready = 1'b0;
    b = wp[0];
    stage(0, 4, 1'b0);
    commit();
    repeat (6) tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_valid got %b exp 1", out_valid); end
    rst = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    vectors++; if (rd_en !== 4'b0000) begin miscompares++; $display("FAIL midrst_rd_en got %b exp 0000", rd_en); end
    rst = 1'b0;
    out_ready = 1'b1;
    wait_acc(2, 30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_resume got %0d flits exp 2", acc_d.size()); end
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        vectors++; if (acc_d[k] !== flit(0, b + 2 + k, 1'b1)) begin miscompares++; $display("FAIL midrst_data[%0d] got %h exp %h", k, acc_d[k], flit(0, b + 2 + k, 1'b1)); end
      end
    end
  endtask

  task automatic test_packet();
    int b0;
    int b1;
    bit ok;
    logic [1:0]    exp_s [4];
    logic [DW-1:0] exp_d [4];
    do_reset();
    clear_logs();
    out_ready = 1'b1;
    b0 = wp[0];
    b1 = wp[1];
    stage(0, 3, 1'b1);
    stage(1, 1, 1'b1);
    commit();
`ifdef NOC_ARB_PKT_LOCK_EN
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd1};
    exp_d = '{flit(0, b0, 1'b0), flit(0, b0 + 1, 1'b0), flit(0, b0 + 2, 1'b1), flit(1, b1, 1'b1)};
`else
    exp_s = '{2'd0, 2'd1, 2'd0, 2'd0};
    exp_d = '{flit(0, b0, 1'b0), flit(1, b1, 1'b1), flit(0, b0 + 1, 1'b0), flit(0, b0 + 2, 1'b1)};
`endif
    wait_acc(4, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pkt_count got %0d exp 4", acc_d.size()); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        vectors++; if (acc_s[k] !== exp_s[k]) begin miscompares++; $display("FAIL pkt_src[%0d] got %0d exp %0d", k, acc_s[k], exp_s[k]); end
        vectors++; if (acc_d[k] !== exp_d[k]) begin miscompares++; $display("FAIL pkt_data[%0d] got %h exp %h", k, acc_d[k], exp_d[k]); end
      end
`ifdef NOC_ARB_PKT_LOCK_EN
      if (pop_c.size() >= 4) begin
        vectors++; if (pop_c[3] <= pop_c[2] + 1) begin miscompares++; $display("FAIL pkt_lock_hold got %0d exp >%0d", pop_c[3], pop_c[2] + 1); end
      end
`endif
    end
  endtask

  task automatic test_onehot();
    vectors++; if (ohbad != 0) begin miscompares++; $display("FAIL onehot_rd_en got %0d multi-bit cycles exp 0", ohbad); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      wp[i]   = 0;
      padd[i] = 0;
    end
    tick();
    tick();
    m_rst = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_lagged_empty();
    test_mid_reset();
    test_packet();
    test_onehot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_fifo_arbiter.md
# noc_fifo_arbiter

- Round-robin read scheduler that shares one NoC output link between N_REQ input FIFOs.
- Each cycle it picks an eligible FIFO, pops one flit, and passes it through a 2-entry output buffer to a valid/ready link.
- It sits between the per-port input FIFOs and the router crossbar/output register, and is the only agent that drives their `rd_en`.

## Interface
- `N_REQ`, 4, number of requester FIFOs (2..8).
- `D_WIDTH`, 16, flit width; bit `D_WIDTH-1` is the tail flag.
- `DEPTH`, 12, depth of each attached FIFO; sets count width `CW = $clog2(DEPTH)+1`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_empty`  in  N_REQ  registered empty flag from each FIFO.
- `req_count`  in  N_REQ*CW  occupancy of each FIFO; FIFO i occupies slice [i*CW +: CW].
- `req_rd_data`  in  N_REQ*D_WIDTH  registered read data of each FIFO; slice [i*D_WIDTH +: D_WIDTH].
- `req_rd_en`  out  N_REQ  one-hot-or-zero pop strobe to each FIFO.
- `out_valid`  out  1  head of the output buffer is valid.
- `out_ready`  in  1  downstream accepts the flit this cycle.
- `out_data`  out  D_WIDTH  head flit.
- `out_src`  out  $clog2(N_REQ)  index of the FIFO that supplied `out_data`.

## Operation
- **Eligibility:** FIFO i is eligible iff `req_count[i] != 0` AND `!req_empty[i]`. Both conditions are required because the FIFO's empty flag lags count by one cycle.
- **Read data timing:** a pop issued in cycle t has its flit on `req_rd_data[i]` in cycle t+1. The arbiter captures it into the output buffer at the end of t+1, tagged with its source index.
- **Pending flag:** `pend` is set in t+1 when a pop was issued in t.
- **Issue rule:** at most one `req_rd_en` bit per cycle. A pop is issued only when both hold:
  - an eligible FIFO exists;
  - `occ + pend - pop_out <= 1`, where `occ` is buffer occupancy (0..2) and `pop_out = out_valid && out_ready`.
- **Round robin:** `rr_ptr` (reset 0) marks the highest-priority index. The search runs rr_ptr, rr_ptr+1, …, modulo N_REQ. After a grant to i, `rr_ptr <= (i+1) mod N_REQ`.
- **Output buffer:** 2-entry FIFO, with `out_valid = (occ != 0)`.
  - Capture and `pop_out` in the same cycle leave `occ` unchanged.
  - The buffer never overflows; the issue rule guarantees this.
- **Count stability:** `req_count` decrements one cycle after a pop. Back-to-back pops from the same FIFO are therefore legal only while it is still eligible under the rule above.
- **Reset mid-operation:** any in-flight pop is discarded and the buffer is emptied. The attached FIFOs share `rst`, so no flit is orphaned.

## Timing
- **Reset values:** `req_rd_en=0`, `out_valid=0`, `out_data=0`, `out_src=0`, `occ=0`, `pend=0`, `rr_ptr=0`.
- **Latency:** pop in cycle t → `out_valid` in t+2, provided the buffer was empty.
- **Throughput:** 1 flit/cycle sustained while `out_ready=1` and any FIFO is eligible (per-flit mode).
- **Backpressure:**
  - `out_ready=0` with `occ=2`: no pop is issued.
  - `out_ready=0` with `occ=1, pend=1`: no pop is issued.
  - `out_data` and `out_src` hold stable while `out_valid && !out_ready`.

## Configuration
- **`NOC_ARB_PKT_LOCK_EN` defined:** packet-locked arbitration.
  - States: IDLE and LOCKED.
  - IDLE → LOCKED on a grant to i. Only FIFO i may be popped while LOCKED.
  - At most one pop is in flight (`pend` blocks issue), giving ≤1 flit per 2 cycles.
  - The tail bit of each captured flit is checked. On tail: → IDLE and `rr_ptr <= (i+1) mod N_REQ`.
  - If FIFO i is not eligible while LOCKED, the arbiter stalls and holds the lock.
- **Not defined:** per-flit round robin as in Operation. The tail bit is ignored and there is no state machine.

## Test plan
- **Reset:** assert `rst` 2 cycles with all FIFOs holding data → all outputs at their reset values. First pop goes to FIFO 0 in the cycle after `rst` deasserts.
- **Single requester:** only FIFO 2 eligible, count 3, `out_ready=1` → pops in cycles t, t+1, t+2; `out_valid` t+2..t+4; `out_src=2`; no 4th pop.
- **Fairness:** all 4 FIFOs count 5, per-flit mode, `out_ready=1` → `out_src` sequence 0,1,2,3,0,1,… and no gaps.
- **Backpressure:** `out_ready=0` for 6 cycles from idle with FIFO 1 loaded → exactly 2 pops, `occ=2`, `out_data` stable. Release `out_ready` → flits in order and no loss.
- **Lagged empty:** FIFO 3 count becomes 1 while `req_empty[3]=1` → no pop that cycle. Pop occurs the next cycle.
- **Packet lock (`NOC_ARB_PKT_LOCK_EN`):** FIFO 0 holds a 3-flit packet (tail on the 3rd), FIFO 1 a 1-flit packet → `out_src` 0,0,0,1. No FIFO 1 pop before FIFO 0's tail is captured.
